// File: rtl/lfsr_pkg.sv
// ============================================================================
// lfsr_pkg : shared types and constants for the LFSR word stream generator
// Rev 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned C_DEFAULT_SEED = 1;

    // Bit-counter width; a single-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_stream_if.sv
// ============================================================================
// lfsr_stream_if : control, configuration and output stream of lfsr_stream
// Rev 1.0 -- optional mode signal present when LFSR_GALOIS_EN is defined
// ============================================================================
`default_nettype none

interface lfsr_stream_if #(
    parameter int NBITS = 8,
    parameter int OUTW  = 8,
    parameter int CNTW  = 16
);
    logic             seed_valid;
    logic [NBITS-1:0] seed;
    logic [NBITS-1:0] taps;
    logic             start;
    logic             stop;
`ifdef LFSR_GALOIS_EN
    logic             mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUTW-1:0]  out_data;
    logic             busy;
    logic             lockup;
    logic [CNTW-1:0]  word_count;

`ifdef LFSR_GALOIS_EN
    modport master (
        output seed_valid, seed, taps, start, stop, mode, out_ready,
        input  out_valid, out_data, busy, lockup, word_count
    );
    modport slave (
        input  seed_valid, seed, taps, start, stop, mode, out_ready,
        output out_valid, out_data, busy, lockup, word_count
    );
`else
    modport master (
        output seed_valid, seed, taps, start, stop, out_ready,
        input  out_valid, out_data, busy, lockup, word_count
    );
    modport slave (
        input  seed_valid, seed, taps, start, stop, out_ready,
        output out_valid, out_data, busy, lockup, word_count
    );
`endif

endinterface

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// lfsr_core : LFSR state register with seed load and single-bit step
// Rev 1.0 -- Galois step selectable via mode when LFSR_GALOIS_EN is defined
// ============================================================================
`default_nettype none

module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int          NBITS    = 8,
    parameter int unsigned RST_SEED = C_DEFAULT_SEED
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [NBITS-1:0] seed,
    input  wire logic             step,
    input  wire logic [NBITS-1:0] taps,
`ifdef LFSR_GALOIS_EN
    input  wire logic             mode,
`endif
    output logic      [NBITS-1:0] q,
    output logic                  out_bit
);

    localparam logic [NBITS-1:0] C_RST_Q = NBITS'(RST_SEED);

    logic [NBITS-1:0] q_q;
    logic [NBITS-1:0] q_d;
    logic [NBITS-1:0] fib_next;
`ifdef LFSR_GALOIS_EN
    logic [NBITS-1:0] gal_next;
`endif

    always_comb begin
        fib_next = {^(q_q & taps), q_q[NBITS-1:1]};
`ifdef LFSR_GALOIS_EN
        gal_next = {1'b0, q_q[NBITS-1:1]} ^ ({NBITS{q_q[0]}} & taps);
`endif
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
`ifdef LFSR_GALOIS_EN
            q_d = mode ? gal_next : fib_next;
`else
            q_d = fib_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= C_RST_Q;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign out_bit = q_q[0];

endmodule

`default_nettype wire

// File: rtl/lfsr_stream.sv
// ============================================================================
// lfsr_stream : packs LFSR bits into words on a valid/ready stream
// Rev 1.0 -- define LFSR_GALOIS_EN to add the runtime Galois/Fibonacci mode
// ============================================================================
`default_nettype none

module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int          NBITS    = 8,
    parameter int          OUTW     = 8,
    parameter int          CNTW     = 16,
    parameter int unsigned RST_SEED = C_DEFAULT_SEED
) (
    input wire logic     clk,
    input wire logic     rst,
    lfsr_stream_if.slave bus
);

    localparam int             CW     = cnt_width(OUTW);
    localparam logic [CW-1:0]  C_LAST = CW'(OUTW - 1);

    state_e            state_q, state_d;
    logic [OUTW-1:0]   acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic [CNTW-1:0]   wc_q, wc_d;

    logic              core_load;
    logic              core_step;
    logic [NBITS-1:0]  lfsr_q;
    logic              lfsr_bit;
    logic              lockup;

    lfsr_core #(
        .NBITS    (NBITS),
        .RST_SEED (RST_SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .seed    (bus.seed),
        .step    (core_step),
        .taps    (bus.taps),
`ifdef LFSR_GALOIS_EN
        .mode    (bus.mode),
`endif
        .q       (lfsr_q),
        .out_bit (lfsr_bit)
    );

    assign lockup = (lfsr_q == '0);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        wc_d        = wc_q;
        core_load   = 1'b0;
        core_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                // stop outranks seed_valid, which outranks start
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.seed_valid) begin
                    core_load = 1'b1;
                    acc_d     = '0;
                    wc_d      = '0;
                end else if (bus.start && !lockup) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                core_step    = 1'b1;
                acc_d[cnt_q] = lfsr_bit;
                if (bus.stop) begin
                    // partial word is dropped but the LFSR keeps the step
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (cnt_q == C_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bus.out_ready) begin
                    wc_d = wc_q + 1'b1;
                    if (stop_pend_q || bus.stop) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            wc_q        <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            wc_q        <= wc_d;
        end
    end

    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.out_data   = acc_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.lockup     = lockup;
    assign bus.word_count = wc_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_stream.sv
// ============================================================================
// tb_lfsr_stream : directed bench with a word-level LFSR model (NBITS=OUTW=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_stream;

    localparam int          NB    = 4;
    localparam int          OW    = 4;
    localparam int          CWD   = 16;
    localparam int unsigned SEED0 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_stream_if #(.NBITS(NB), .OUTW(OW), .CNTW(CWD)) bus ();

    lfsr_stream #(
        .NBITS    (NB),
        .OUTW     (OW),
        .CNTW     (CWD),
        .RST_SEED (SEED0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_chk = 0;
    int            n_err = 0;
    logic [NB-1:0] m_q;
    logic [15:0]   m_wc;
    logic          m_mode;
    logic          prev_valid;
    logic          prev_hs;
    logic [OW-1:0] prev_data;
    logic [OW-1:0] got_q[$];
    // period-15 bitstream for taps 0011 from seed 0001, element i in bit i
    logic [14:0]   seq15;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next state by arithmetic: shift right, feedback parity into MSB or XOR taps in.
    function automatic logic [NB-1:0] m_step(input logic [NB-1:0] q, input logic [NB-1:0] t,
                                              input logic md);
        int par;
        if (md) begin
            return (q >> 1) ^ ((q % 2 == 1) ? t : '0);
        end
        par = $countones(q & t) % 2;
        return (q >> 1) | (par != 0 ? NB'(1 << (NB - 1)) : '0);
    endfunction

    function automatic logic [OW-1:0] m_word();
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < OW; i++) begin
            w[i] = m_q[0];
            m_q  = m_step(m_q, bus.taps, m_mode);
        end
        return w;
    endfunction

    task automatic m_skip(input int n);
        for (int i = 0; i < n; i++) m_q = m_step(m_q, bus.taps, m_mode);
    endtask

    task automatic compare();
        logic [OW-1:0] exp;
        chk("word_count", 32'(bus.word_count), 32'(m_wc));
        if (prev_valid && !prev_hs) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(prev_data));
        end
        if (bus.out_valid && bus.out_ready) begin
            exp = m_word();
            chk("model_word", 32'(bus.out_data), 32'(exp));
            got_q.push_back(bus.out_data);
            m_wc = m_wc + 16'd1;
        end
        prev_valid = bus.out_valid;
        prev_data  = bus.out_data;
        prev_hs    = bus.out_valid && bus.out_ready;
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk("valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic load_seed(input logic [NB-1:0] s);
        bus.seed       = s;
        bus.seed_valid = 1'b1;
        cyc();
        bus.seed_valid = 1'b0;
        m_q  = s;
        m_wc = 16'd0;
    endtask

    task automatic start_gen();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic model_reset();
        m_q        = NB'(SEED0);
        m_wc       = 16'd0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_data  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            n;
        logic [OW-1:0] w;
        seq15          = 15'b1110101_10010001;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.taps       = 4'b0011;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.out_ready  = 1'b1;
        m_mode         = 1'b0;
`ifdef LFSR_GALOIS_EN
        bus.mode       = 1'b0;
`endif
        model_reset();

        // reset state
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_lockup", 32'(bus.lockup), 32'd0);
        chk("rst_count", 32'(bus.word_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // first words with ready high: latency OUTW, period OUTW+1
        start_gen();
        wait_valid(n);
        chk("lat_first", 32'(n), 32'd4);
        chk("word1", 32'(bus.out_data), 32'h1);
        chk("busy_run", 32'(bus.busy), 32'd1);
        cyc();
        wait_valid(n);
        chk("lat_second", 32'(n), 32'd4);
        chk("word2", 32'(bus.out_data), 32'h9);
        chk("count1", 32'(bus.word_count), 32'd1);
        cyc();
        wait_valid(n);
        chk("word3", 32'(bus.out_data), 32'h5);
        chk("count2", 32'(bus.word_count), 32'd2);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("count3", 32'(bus.word_count), 32'd3);
        chk("idle_after_hs_stop", 32'(bus.busy), 32'd0);

        // backpressure in HOLD, then stop while held
        load_seed(4'b0001);
        bus.out_ready = 1'b0;
        start_gen();
        wait_valid(n);
        for (int i = 0; i < 10; i++) cyc();
        chk("held_data", 32'(bus.out_data), 32'h1);
        chk("held_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("bp_count", 32'(bus.word_count), 32'd1);
        wait_valid(n);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("stop_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("stop_hold_data", 32'(bus.out_data), 32'h9);
        bus.out_ready = 1'b1;
        cyc();
        chk("stop_hold_idle", 32'(bus.busy), 32'd0);
        chk("stop_hold_count", 32'(bus.word_count), 32'd2);

        // stop in the third RUN cycle drops the partial word
        load_seed(4'b0001);
        start_gen();
        cyc();
        cyc();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        m_skip(3);
        chk("run_stop_idle", 32'(bus.busy), 32'd0);
        cyc();
        cyc();
        chk("run_stop_novalid", 32'(bus.out_valid), 32'd0);
        chk("run_stop_count", 32'(bus.word_count), 32'd0);
        start_gen();
        wait_valid(n);
        chk("restart_lat", 32'(n), 32'd4);
        chk("restart_word", 32'(bus.out_data), 32'h2);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;

        // zero seed: lockup and refused start
        load_seed(4'b0000);
        chk("lockup", 32'(bus.lockup), 32'd1);
        start_gen();
        for (int i = 0; i < 5; i++) cyc();
        chk("lock_busy", 32'(bus.busy), 32'd0);
        chk("lock_valid", 32'(bus.out_valid), 32'd0);
        chk("lock_still", 32'(bus.lockup), 32'd1);

        // free run 15 words: bitstream period 15
        load_seed(4'b0001);
        chk("unlock", 32'(bus.lockup), 32'd0);
        got_q.delete();
        start_gen();
        for (int k = 0; k < 15; k++) begin
            wait_valid(n);
            cyc();
        end
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("free_count", 32'(bus.word_count), 32'd15);
        chk("free_words", 32'(got_q.size()), 32'd15);
        for (int k = 0; k < 15 && k < got_q.size(); k++) begin
            for (int b = 0; b < OW; b++) w[b] = seq15[(k * OW + b) % 15];
            chk("period15", 32'(got_q[k]), 32'(w));
        end

`ifdef LFSR_GALOIS_EN
        // Galois mode: taps 0011 from 0001 gives bits 1,1,0 repeating
        m_mode   = 1'b1;
        bus.mode = 1'b1;
        load_seed(4'b0001);
        got_q.delete();
        start_gen();
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            cyc();
        end
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("galois_first", 32'(got_q.size() > 0 ? got_q[0] : 4'h0), 32'hB);
        chk("galois_third", 32'(got_q.size() > 2 ? got_q[2] : 4'h0), 32'h6);
        m_mode   = 1'b0;
        bus.mode = 1'b0;
`endif

        // asynchronous reset mid-HOLD discards the held word
        load_seed(4'b0110);
        bus.out_ready = 1'b0;
        start_gen();
        wait_valid(n);
        rst = 1'b0;
        #2;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_count", 32'(bus.word_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        start_gen();
        wait_valid(n);
        chk("post_rst_word", 32'(bus.out_data), 32'h1);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("post_rst_count", 32'(bus.word_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
